// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for NUM_DIGITS seven-segment digits.
//
// Ports:
//   clk      - single clock, all state changes on its rising edge
//   reset    - synchronous, active-high reset
//   cs       - write strobe: latches i_data, i_dp, i_blank on this edge
//   i_data   - one hex nibble per digit, digit k in bits [4k+3:4k]
//   i_dp     - decimal point per digit (1 = lit)
//   i_blank  - forced blank per digit (1 = dark)
//   lz_en    - leading-zero suppression enable (live)
//   bright   - brightness 0..15 (live); sets lit cycles per slot
//   o_seg    - registered segments {dp,g,f,e,d,c,b,a}
//   o_sel    - registered one-hot digit select
//   o_frame  - registered one-cycle pulse after the last digit slot wraps
module seg7_scan #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 64,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cs,
  input  logic [4*NUM_DIGITS-1:0]   i_data,
  input  logic [NUM_DIGITS-1:0]     i_dp,
  input  logic [NUM_DIGITS-1:0]     i_blank,
  input  logic                      lz_en,
  input  logic [3:0]                bright,
  output logic [7:0]                o_seg,
  output logic [NUM_DIGITS-1:0]     o_sel,
  output logic                      o_frame
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]           r_pcnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_data;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_blank;

  logic                    w_pwrap;
  logic                    w_iwrap;
  logic [31:0]             w_limit;
  logic                    w_active;
  logic [3:0]              w_nib;
  logic [NUM_DIGITS-1:0]   w_upper_zero;
  logic                    w_run;
  logic                    w_dark;
  logic [6:0]              w_hex;
  logic [7:0]              w_seg_ah;
  logic [NUM_DIGITS-1:0]   w_sel_ah;

  assign w_pwrap  = (r_pcnt == PW'(SCAN_DIV - 1));
  assign w_iwrap  = (r_idx == IW'(NUM_DIGITS - 1));

  // pcnt==0 is always dark, so even bright=15 leaves a dead cycle per slot
  assign w_limit  = (32'(bright) + 32'd1) * (SCAN_DIV / 16);
  assign w_active = (r_pcnt != '0) && (32'(r_pcnt) < w_limit);

  assign w_nib    = r_data[{r_idx, 2'b00} +: 4];

  // w_upper_zero[k]: nibbles k..NUM_DIGITS-1 are all zero
  always_comb begin
    w_run        = 1'b1;
    w_upper_zero = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      w_run = w_run & (r_data[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
      w_upper_zero[NUM_DIGITS-1-i] = w_run;
    end
  end

  assign w_dark = r_blank[r_idx] | (lz_en & (r_idx != '0) & w_upper_zero[r_idx]);

  always_comb begin
    w_hex = 7'h00;
    case (w_nib)
      4'h0: w_hex = 7'h3F;
      4'h1: w_hex = 7'h06;
      4'h2: w_hex = 7'h5B;
      4'h3: w_hex = 7'h4F;
      4'h4: w_hex = 7'h66;
      4'h5: w_hex = 7'h6D;
      4'h6: w_hex = 7'h7D;
      4'h7: w_hex = 7'h07;
      4'h8: w_hex = 7'h7F;
      4'h9: w_hex = 7'h6F;
      4'hA: w_hex = 7'h77;
      4'hB: w_hex = 7'h7C;
      4'hC: w_hex = 7'h39;
      4'hD: w_hex = 7'h5E;
      4'hE: w_hex = 7'h79;
      4'hF: w_hex = 7'h71;
      default: w_hex = 7'h00;
    endcase
  end

  always_comb begin
    w_seg_ah = '0;
    w_sel_ah = '0;
    if (w_active) begin
      w_sel_ah[r_idx] = 1'b1;
      if (!w_dark) w_seg_ah = {r_dp[r_idx], w_hex};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcnt  <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_dp    <= '0;
      r_blank <= '0;
      o_seg   <= ACTIVE_LOW ? '1 : '0;
      o_sel   <= ACTIVE_LOW ? '1 : '0;
      o_frame <= 1'b0;
    end else begin
      r_pcnt <= w_pwrap ? '0 : r_pcnt + 1'b1;
      if (w_pwrap) r_idx <= w_iwrap ? '0 : r_idx + 1'b1;
      if (cs) begin
        r_data  <= i_data;
        r_dp    <= i_dp;
        r_blank <= i_blank;
      end
      o_seg   <= ACTIVE_LOW ? ~w_seg_ah : w_seg_ah;
      o_sel   <= ACTIVE_LOW ? ~w_sel_ah : w_sel_ah;
      o_frame <= w_pwrap & w_iwrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: self-checking bench for seg7_scan (8 digits, 16 cycles/slot,
// active-low). A cycle model pushes the expected outputs of every edge onto a
// scoreboard queue; a checker pops and compares them 1 ns after the edge.
// Directed checks against fixed constants cover the documented scenarios.
module tb_seg7_scan;

  localparam int unsigned ND = 8;
  localparam int unsigned SD = 16;

  logic          clk;
  logic          reset;
  logic          cs;
  logic [4*ND-1:0] i_data;
  logic [ND-1:0] i_dp;
  logic [ND-1:0] i_blank;
  logic          lz_en;
  logic [3:0]    bright;
  logic [7:0]    o_seg;
  logic [ND-1:0] o_sel;
  logic          o_frame;

  seg7_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .cs(cs), .i_data(i_data), .i_dp(i_dp),
    .i_blank(i_blank), .lz_en(lz_en), .bright(bright),
    .o_seg(o_seg), .o_sel(o_sel), .o_frame(o_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  typedef struct {
    logic [7:0] seg;
    logic [7:0] sel;
    logic       frame;
  } exp_t;

  exp_t sb [$];

  // Reference model state
  int          m_pcnt, m_idx;
  int          m_out_pcnt = -1, m_out_idx = -1;
  logic [31:0] m_data;
  logic [7:0]  m_dp, m_blank;
  bit          started = 0;

  always @(posedge clk) begin
    exp_t e;
    bit   act, dark, allz;
    logic [7:0] seg, sel;
    if (reset) begin
      e.seg = 8'hFF; e.sel = 8'hFF; e.frame = 1'b0;
      m_pcnt = 0; m_idx = 0; m_data = '0; m_dp = '0; m_blank = '0;
      m_out_pcnt = -1; m_out_idx = -1;
      started = 1;
    end else begin
      act  = (m_pcnt != 0) && (m_pcnt < (int'(bright) + 1) * (SD / 16));
      allz = 1;
      for (int k = m_idx; k < ND; k++) if (m_data[k*4 +: 4] != 4'h0) allz = 0;
      dark = m_blank[m_idx] || (lz_en && m_idx > 0 && allz);
      seg  = (act && !dark) ? {m_dp[m_idx], hex7(m_data[m_idx*4 +: 4])} : 8'h00;
      sel  = act ? (8'h01 << m_idx) : 8'h00;
      e.seg = ~seg; e.sel = ~sel;
      e.frame = (m_pcnt == SD - 1) && (m_idx == ND - 1);
      m_out_pcnt = m_pcnt; m_out_idx = m_idx;
      if (m_pcnt == SD - 1) begin
        m_pcnt = 0;
        m_idx  = (m_idx == ND - 1) ? 0 : m_idx + 1;
      end else m_pcnt = m_pcnt + 1;
      if (cs) begin m_data = i_data; m_dp = i_dp; m_blank = i_blank; end
    end
    if (started) sb.push_back(e);
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("sb_seg",   32'(o_seg),   32'(e.seg));
      check_eq("sb_sel",   32'(o_sel),   32'(e.sel));
      check_eq("sb_frame", 32'(o_frame), 32'(e.frame));
    end
  end

  // Wait until the outputs on display belong to digit d, pcnt p
  task automatic wait_pos(input int d, input int p);
    bit found = 0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge clk);
      if (m_out_idx == d && m_out_pcnt == p) found = 1;
    end
    check_eq("wait_pos", 32'(found), 32'd1);
  endtask

  // Wait until the next edge will see digit d, pcnt p
  task automatic wait_state(input int d, input int p);
    bit found = 0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge clk);
      if (m_idx == d && m_pcnt == p) found = 1;
    end
    check_eq("wait_state", 32'(found), 32'd1);
  endtask

  task automatic write(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
    @(negedge clk);
    i_data = d; i_dp = dp; i_blank = bl; cs = 1'b1;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic at_pos(input string tag, input int d, input int p,
                        input logic [7:0] sel, input logic [7:0] seg);
    wait_pos(d, p);
    check_eq({tag, "_sel"}, 32'(o_sel), 32'(sel));
    check_eq({tag, "_seg"}, 32'(o_seg), 32'(seg));
  endtask

  task automatic count_active(input string tag, input int exp);
    int cnt = 0;
    wait_pos(2, 0);
    for (int n = 0; n < SD; n++) begin
      if (n > 0) @(negedge clk);
      if (o_sel != 8'hFF) cnt++;
    end
    check_eq(tag, 32'(cnt), 32'(exp));
  endtask

  initial begin
    bit found;
    int per;
    reset = 1'b1; cs = 1'b0; i_data = '0; i_dp = '0; i_blank = '0;
    lz_en = 1'b0; bright = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_seg",   32'(o_seg),   32'hFF);
    check_eq("rst_sel",   32'(o_sel),   32'hFF);
    check_eq("rst_frame", 32'(o_frame), 32'h0);
    @(negedge clk) reset = 1'b0;

    // Basic scan
    bright = 4'd15;
    write(32'h76543210, 8'h00, 8'h00);
    at_pos("d0", 0, 5, 8'hFE, 8'hC0);
    at_pos("d0_last", 0, 15, 8'hFE, 8'hC0);
    at_pos("d3", 3, 5, 8'hF7, 8'hB0);

    found = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      if (o_frame) found = 1;
    end
    check_eq("frame_seen", 32'(found), 32'd1);
    per = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      per++;
      if (o_frame) break;
    end
    check_eq("frame_period", 32'(per), 32'd128);

    // Brightness and dead time
    bright = 4'd1;  count_active("bright1", 1);
    bright = 4'd7;  count_active("bright7", 7);
    bright = 4'd0;  count_active("bright0", 0);
    bright = 4'd15; count_active("bright15", 15);

    // Leading-zero suppression
    lz_en = 1'b1;
    write(32'h00000A05, 8'h00, 8'h00);
    at_pos("lz_d7", 7, 5, 8'h7F, 8'hFF);
    at_pos("lz_d3", 3, 5, 8'hF7, 8'hFF);
    at_pos("lz_d2", 2, 5, 8'hFB, 8'h88);
    at_pos("lz_d1", 1, 5, 8'hFD, 8'hC0);
    at_pos("lz_d0", 0, 5, 8'hFE, 8'h92);
    write(32'h00000000, 8'h00, 8'h00);
    at_pos("z_d0", 0, 5, 8'hFE, 8'hC0);
    at_pos("z_d1", 1, 5, 8'hFD, 8'hFF);
    at_pos("z_d4", 4, 5, 8'hEF, 8'hFF);

    // Blank and decimal point
    lz_en = 1'b0;
    write(32'h00000011, 8'h02, 8'h01);
    at_pos("bl_d0", 0, 5, 8'hFE, 8'hFF);
    at_pos("dp_d1", 1, 5, 8'hFD, 8'h79);

    // Write coincident with the idx 7->0 wrap
    write(32'h76543210, 8'h00, 8'h00);
    wait_state(7, 15);
    i_data = 32'h0000000C; i_dp = '0; i_blank = '0; cs = 1'b1;
    @(negedge clk) cs = 1'b0;
    at_pos("wrap_d0", 0, 1, 8'hFE, 8'hC6);

    // Reset mid-slot
    write(32'h12345678, 8'hFF, 8'h00);
    wait_state(5, 9);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("mrst_seg",   32'(o_seg),   32'hFF);
    check_eq("mrst_sel",   32'(o_sel),   32'hFF);
    check_eq("mrst_frame", 32'(o_frame), 32'h0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check_eq("restart_dead_sel", 32'(o_sel), 32'hFF);
    @(posedge clk); #1;
    check_eq("restart_d0_sel", 32'(o_sel), 32'hFE);
    check_eq("restart_d0_seg", 32'(o_seg), 32'hC0);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
